// File: rtl/div_req_ctrl.sv
// Request controller in front of the divider core: handles zero/overflow locally, sequences start/done, fixes signs.
// Latency 1 cycle for local results, 2 + core cycles otherwise; in_ready only in IDLE, result held until out_ready.
module div_req_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             core_start,
  output logic [WIDTH-1:0] core_src1,
  output logic [WIDTH-1:0] core_src2,
  input  logic [WIDTH-1:0] core_qut,
  input  logic [WIDTH-1:0] core_rmd,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_qut,
  output logic [WIDTH-1:0] out_rmd,
  output logic             out_dbz,
  output logic             out_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             is_dbz;
  logic             is_ovf;
  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_dbz   = (in_divisor == '0);
  assign is_ovf   = in_signed && (in_dividend == MIN_NEG) && (in_divisor == '1);
  // Negating the most negative value wraps to itself, which the unsigned core divides correctly.
  assign mag_dvd  = (in_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
  assign mag_dvs  = (in_signed && in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_src1  <= '0;
      core_src2  <= '0;
      out_valid  <= 1'b0;
      out_qut    <= '0;
      out_rmd    <= '0;
      out_dbz    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q   <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            neg_r   <= in_signed && in_dividend[WIDTH-1];
            cnt     <= '0;
            out_dbz <= 1'b0;
            out_err <= 1'b0;
            if (is_dbz) begin
              out_qut   <= '1;
              out_rmd   <= in_dividend;
              out_dbz   <= 1'b1;
              out_valid <= 1'b1;
              state     <= RESP;
            end else if (is_ovf) begin
              out_qut   <= MIN_NEG;
              out_rmd   <= '0;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              core_src1  <= mag_dvd;
              core_src2  <= mag_dvs;
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          // A done in the final allowed cycle wins over the timeout.
          if (core_done) begin
            out_qut   <= neg_q ? -core_qut : core_qut;
            out_rmd   <= neg_r ? -core_rmd : core_rmd;
            out_dbz   <= 1'b0;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_qut   <= '0;
            out_rmd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Bench for div_req_ctrl: directed vector table, timeout/hold/reset sequences, and random requests vs. an arithmetic model.
module tb_div_req_ctrl;

  localparam int TMO = 63;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [31:0] in_dividend = '0;
  logic [31:0] in_divisor = '0;
  logic        core_start;
  logic [31:0] core_src1;
  logic [31:0] core_src2;
  logic [31:0] core_qut = '0;
  logic [31:0] core_rmd = '0;
  logic        core_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_qut;
  logic [31:0] out_rmd;
  logic        out_dbz;
  logic        out_err;

  div_req_ctrl #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .core_start(core_start), .core_src1(core_src1), .core_src2(core_src2),
    .core_qut(core_qut), .core_rmd(core_rmd), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_qut(out_qut), .out_rmd(out_rmd), .out_dbz(out_dbz), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Divider core model: answers lat cycles after seeing start; lat 0 means it never answers.
  int          core_lat = 1;
  int          cd = 0;
  bit          busy = 1'b0;
  bit          spurious = 1'b0;
  int          start_cnt = 0;
  logic [31:0] seen_src1 = '0;
  logic [31:0] seen_src2 = '0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (spurious) begin
      core_done = 1'b1;
      core_qut  = 32'hDEAD_BEEF;
      core_rmd  = 32'h1234_5678;
    end
    if (busy) begin
      cd--;
      if (cd == 0) begin
        core_done = 1'b1;
        core_qut  = (seen_src2 == 0) ? '1 : seen_src1 / seen_src2;
        core_rmd  = (seen_src2 == 0) ? seen_src1 : seen_src1 % seen_src2;
        busy      = 1'b0;
      end
    end
    if (core_start === 1'b1) begin
      start_cnt++;
      seen_src1 = core_src1;
      seen_src2 = core_src2;
      if (core_lat > 0) begin
        busy = 1'b1;
        cd   = core_lat;
      end
    end
  end

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          hold;
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    bit          err;
    bit          core;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input int hold, input logic [31:0] q,
                              input logic [31:0] r, input bit dbz, input bit err, input bit core);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.lat = lat; v.hold = hold;
    v.q = q; v.r = r; v.dbz = dbz; v.err = err; v.core = core;
    return v;
  endfunction

  // Reference: plain signed/unsigned arithmetic with truncating division on 64-bit values.
  function automatic vec_t ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   input int lat, input int hold);
    vec_t   v;
    longint sa;
    longint sb;
    v = mk(sgn, a, b, lat, hold, '0, '0, 1'b0, 1'b0, 1'b1);
    if (b == 0) begin
      v.q = '1; v.r = a; v.dbz = 1'b1; v.core = 1'b0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v.q = 32'(sa / sb);
      v.r = 32'(sa % sb);
      v.core = !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    end else begin
      v.q = a / b;
      v.r = a % b;
    end
    if (lat == 0 && v.core) begin
      v.q = '0; v.r = '0; v.err = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
    longint s;
    s = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    if (s < 0) s = -s;
    return 32'(s);
  endfunction

  task automatic do_txn(input vec_t v);
    int cyc;
    int s0;
    int rdy_busy;
    int exp_lat;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step;
      cyc++;
    end
    check("in_ready_idle", in_ready, 1);
    s0 = start_cnt;
    core_lat = v.lat;
    in_valid = 1'b1; in_signed = v.sgn; in_dividend = v.a; in_divisor = v.b;
    step;
    in_valid = 1'b0; in_signed = 1'($urandom); in_dividend = $urandom; in_divisor = $urandom;
    cyc = 1;
    rdy_busy = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) rdy_busy++;
      step;
      cyc++;
    end
    exp_lat = !v.core ? 1 : (v.err ? TMO + 2 : v.lat + 2);
    check("latency", cyc, exp_lat);
    check("in_ready_busy", rdy_busy, 0);
    check("quotient", out_qut, v.q);
    check("remainder", out_rmd, v.r);
    check("dbz", out_dbz, v.dbz);
    check("err", out_err, v.err);
    check("start_pulses", start_cnt - s0, v.core ? 1 : 0);
    if (v.core) begin
      check("src1", seen_src1, mag(v.sgn, v.a));
      check("src2", seen_src2, mag(v.sgn, v.b));
    end
    for (int i = 0; i < v.hold; i++) begin
      if (i == 1) spurious = 1'b1;
      step;
      spurious = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_qut", out_qut, v.q);
      check("hold_rmd", out_rmd, v.r);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   s0;
    int   bad;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;

    tbl.push_back(mk(0, 32'd100,        32'd7,          3, 0, 32'd14,        32'd2,        0, 0, 1));
    tbl.push_back(mk(1, 32'hFFFF_FFF9,  32'd2,          5, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 1));
    tbl.push_back(mk(1, 32'd20,         32'hFFFF_FFFA,  1, 0, 32'hFFFF_FFFD, 32'd2,        0, 0, 1));
    tbl.push_back(mk(0, 32'd5,          32'd0,          2, 0, 32'hFFFF_FFFF, 32'd5,        1, 0, 0));
    tbl.push_back(mk(1, 32'h8000_0000,  32'hFFFF_FFFF,  2, 0, 32'h8000_0000, 32'd0,        0, 0, 0));
    tbl.push_back(mk(0, 32'h8000_0000,  32'hFFFF_FFFF,  2, 0, 32'd0,         32'h8000_0000, 0, 0, 1));
    tbl.push_back(mk(1, 32'h8000_0000,  32'd2,          4, 0, 32'hC000_0000, 32'd0,        0, 0, 1));
    tbl.push_back(mk(1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  2, 0, 32'd3,         32'hFFFF_FFFF, 0, 0, 1));
    tbl.push_back(mk(0, 32'd1000,       32'd10,         2, 10, 32'd100,      32'd0,        0, 0, 1));
    tbl.push_back(mk(1, 32'hFFFF_FFF0,  32'd0,          2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 0, 0));
    tbl.push_back(mk(0, 32'd9,          32'd3,          0, 2, 32'd0,         32'd0,        0, 1, 1));
    tbl.push_back(mk(0, 32'd9,          32'd4,        TMO, 0, 32'd2,         32'd1,        0, 0, 1));

    step;
    n_rst = 1'b0;
    repeat (3) step;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_qut", out_qut, 0);
    check("rst_out_rmd", out_rmd, 0);
    check("rst_flags", {out_dbz, out_err}, 0);
    check("rst_src", {core_src1, core_src2} == 64'd0, 1);
    n_rst = 1'b1;
    step;

    foreach (tbl[i]) do_txn(tbl[i]);

    // Reset while the core is busy; its late done must not leak out.
    core_lat = 20;
    in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd50; in_divisor = 32'd5;
    step;
    in_valid = 1'b0;
    repeat (4) step;
    check("pre_reset_busy", in_ready, 0);
    s0 = start_cnt;
    n_rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_src1", core_src1, 0);
    check("mid_rst_src2", core_src2, 0);
    check("mid_rst_out", {out_qut, out_rmd} == 64'd0, 1);
    check("mid_rst_flags", {out_dbz, out_err}, 0);
    repeat (2) step;
    n_rst = 1'b1;
    bad = 0;
    repeat (25) begin
      step;
      if (out_valid || !in_ready || core_start) bad++;
    end
    check("stale_done_ignored", bad, 0);
    check("no_start_after_reset", start_cnt - s0, 0);
    do_txn(mk(0, 32'd100, 32'd7, 3, 0, 32'd14, 32'd2, 0, 0, 1));

    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom);
      case ($urandom_range(3, 0))
        0:       a = $urandom_range(1000, 0);
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(7, 0))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(20, 1);
        4:       b = -($urandom_range(20, 1));
        default: b = $urandom;
      endcase
      v = ref_div(sgn, a, b, $urandom_range(8, 1), $urandom_range(3, 0));
      do_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_req_ctrl.md
Name: div_req_ctrl

Overview:
- Request-side controller placed directly upstream of the 32-bit non-restoring unsigned divider core.
- Accepts signed/unsigned divide requests over a valid/ready handshake and converts operands to magnitudes.
- Handles divide-by-zero and signed overflow locally, without using the core.
- Issues a one-cycle start pulse to the core, captures its quotient/remainder on its done pulse, applies sign correction, and returns the result over a valid/ready output handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the core width.
- TIMEOUT, 63, maximum cycles spent in WAIT for core_done before an error response.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- in_signed  input  1  1 = signed division, 0 = unsigned
- in_dividend  input  WIDTH  dividend
- in_divisor  input  WIDTH  divisor
- core_start  output  1  one-cycle start pulse to the divider core
- core_src1  output  WIDTH  dividend magnitude to the core
- core_src2  output  WIDTH  divisor magnitude to the core
- core_qut  input  WIDTH  core quotient, valid in the core_done cycle
- core_rmd  input  WIDTH  core remainder, valid in the core_done cycle
- core_done  input  1  core completion pulse
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_qut  output  WIDTH  final quotient
- out_rmd  output  WIDTH  final remainder
- out_dbz  output  1  divide-by-zero flag
- out_err  output  1  core timeout flag

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- Reset values: state=IDLE; core_start, out_valid, out_dbz, out_err = 0; out_qut, out_rmd, core_src1, core_src2, the timeout counter and all operand/sign registers = 0.
- in_ready = 1 only in IDLE (combinational from state).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: an accept is in_valid && in_ready. On accept, register operands, in_signed, neg_q = signed && (dividend[MSB] ^ divisor[MSB]), and neg_r = signed && dividend[MSB].
  - Divisor == 0: out_qut = all ones, out_rmd = dividend, out_dbz = 1; go to RESP. out_valid is high the cycle after accept.
  - Signed, dividend = 0x80000000 and divisor = 0xFFFFFFFF: out_qut = 0x80000000, out_rmd = 0; go to RESP.
  - Otherwise: core_src1/core_src2 = two's-complement magnitudes when signed (raw values when unsigned); go to ISSUE.
- ISSUE: core_start = 1 for exactly this one cycle; core_src1/core_src2 are stable; go to WAIT.
- core_src1/core_src2 hold their values from ISSUE until the next accept.
- WAIT: counter increments each cycle.
  - On core_done: out_qut = neg_q ? -core_qut : core_qut; out_rmd = neg_r ? -core_rmd : core_rmd; out_dbz = 0; out_err = 0; go to RESP.
  - If the counter reaches TIMEOUT with no core_done: out_qut = 0, out_rmd = 0, out_err = 1; go to RESP. A core_done arriving in the same cycle takes priority over the timeout.
- RESP: out_valid = 1. out_qut, out_rmd, out_dbz and out_err are held stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE. A new request can be accepted the cycle after the handshake (no same-cycle turnaround).
- Negation is WIDTH-bit two's complement; -0x80000000 = 0x80000000. This makes the unsigned core result correct for magnitude 2^31.
- core_done outside WAIT is ignored.
- Flags are cleared on every accept.
- Latency for a core operation = 1 (ISSUE) + core cycles + 1 (capture) until out_valid.
- Reset mid-operation: immediately IDLE with all outputs at reset values. core_start does not pulse during reset; a stale core_done after reset is ignored.

Test Plan:
- Unsigned 100/7 -> core_start pulses once with src1=100, src2=7; out_qut=14, out_rmd=2, out_dbz=0.
- Signed 0xFFFFFFF9 (-7) / 2 -> core_src1=7, core_src2=2; out_qut=0xFFFFFFFD, out_rmd=0xFFFFFFFF.
- Signed 20 / 0xFFFFFFFA (-6) -> out_qut=0xFFFFFFFD, out_rmd=2.
- Divide by zero 5/0 -> core_start never asserted; out_valid the cycle after accept; out_qut=0xFFFFFFFF, out_rmd=5, out_dbz=1.
- Signed 0x80000000 / 0xFFFFFFFF -> no core_start; out_qut=0x80000000, out_rmd=0.
- Hold out_ready=0 for 10 cycles in RESP -> out_valid and data stable, in_ready=0. Separately, core model never asserts done -> out_err=1 after TIMEOUT cycles. Separately, pull n_rst low in WAIT -> all outputs 0 and in_ready=1 after reset.
